vram_hdma_ctrl: RTL and testbench
=================================

# vram_hdma_ctrl

CGB VRAM DMA controller for registers FF51–FF55. It copies 16-byte blocks from a source address into VRAM bank 0 or bank 1. General-purpose DMA (GDMA) copies all blocks back-to-back. H-blank DMA (HDMA) copies one block at each H-blank entry. The block sits next to the PPU: it drives the PPU's DMA-write port and `dma_sel_VRAM_bank*` muxes, and it stalls the CPU while a transfer runs.

## Interface
Parameters:
- none; block size fixed at 16 bytes, length field 7 bits.

Ports:
- clk4_2  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- reg_addr  in  16  CPU address bus (`address_bus_offset`)
- reg_we  in  1  CPU write strobe, one cycle per write
- reg_wdata  in  8  CPU write data
- VBK  in  1  VRAM bank select, sampled on FF55 start write
- STAT_mode  in  2  PPU mode (00 H-blank, 01 V-blank, 10 OAM, 11 transfer)
- LCD_on  in  1  LCDC[7]
- src_rdata  in  8  source read data, valid one cycle after `src_en`
- src_addr  out  16  source read address
- src_en  out  1  source read strobe
- address_bus_dma_wr  out  16  VRAM write address = {3'b100, dst[12:0]}
- mem_enable_dma_wr  out  1  VRAM enable during write cycle
- data_in_dma_wr  out  8  write data (`src_rdata` registered)
- wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr  out  1 each  per-bank write enables
- dma_sel_VRAM_bank0, dma_sel_VRAM_bank1  out  2 each  2'b10 on the target bank while active, else 2'b00
- cpu_stall  out  1  CPU hold
- hdma_status  out  8  FF55 readback value

## Operation
Register writes:
- FF51/FF52 load src[15:8] / src[7:4]; src[3:0] forced to 0.
- FF53/FF54 load dst[12:8] (wdata[4:0]) / dst[7:4]; dst[3:0] forced to 0.
- FF51–FF54 writes are ignored while busy.
- FF55 write while idle: blocks_left = wdata[6:0]+1, bank = VBK.
  - wdata[7]=0: start GDMA.
  - wdata[7]=1: start HDMA.
- FF55 write with bit7=0 during HDMA: cancel; ends in IDLE and no further bytes are transferred.
- FF55 write with bit7=1 during HDMA: ignored.

States:
- IDLE
- RD: src_en=1, src_addr=src.
- WR: write enable for the target bank, mem_enable_dma_wr=1. After the write, src+1 and dst[12:0]+1 (13-bit wrap; VRAM address stays in 0x8000–0x9FFF). src wraps FFFF→0000.
- WAIT_HB: HDMA waiting for an H-blank edge.
- HOLD: HDMA block done, waiting for STAT_mode ≠ 00.

Transitions:
- RD→WR always.
- WR→RD while byte count in the block < 15.
- At the end of a block, blocks_left decrements.
  - GDMA: RD if blocks_left > 0, else IDLE.
  - HDMA: HOLD if blocks_left > 0, else IDLE.
- IDLE→RD on GDMA start.
- IDLE→WAIT_HB on HDMA start.
- WAIT_HB→RD on an edge of STAT_mode from non-00 to 00, with LCD_on=1.
- HOLD→WAIT_HB when STAT_mode ≠ 00.
- A start during H-blank waits for the next H-blank.
- LCD_on=0 freezes WAIT_HB; no transfer happens.

Outputs:
- cpu_stall=1 in RD and WR only.
- dma_sel=2'b10 on the target bank whenever the state is not IDLE.

hdma_status:
- Active: {1'b0, blocks_left-1}.
- After completion or reset: 0xFF.
- After cancel: {1'b1, blocks_left-1}.

Reset:
- All outputs 0 except hdma_status = 0xFF.
- State IDLE; src, dst, counters cleared.
- A reset mid-transfer aborts the transfer immediately.

## Timing
- FF55 write sampled at edge N.
- GDMA: byte k is read at edge N+1+2k and written at edge N+2+2k.
- L blocks finish with the last write at edge N+32L; IDLE and status 0xFF from N+32L+1.
- cpu_stall spans exactly 32L cycles for GDMA.
- HDMA: first RD one cycle after the H-blank edge is detected. Each block takes 32 cycles with cpu_stall high, then HOLD.
- blocks_left and status update on the edge that ends a block's last WR.
- A cancel takes effect on the edge after the write is sampled.

## Test plan
- GDMA: FF51=C0, FF52=00, FF53=00, FF54=00, VBK=0, FF55=00 → 16 writes 0x8000–0x800F on bank 0 with data = source bytes; cpu_stall high for exactly 32 cycles; status 0xFF afterward.
- Nibble masking and bank: FF52=0F, FF54=1F, VBK=1 → src starts 0xC000, dst 0x8010, only wr_en_VRAM_bank1_dma_wr toggles, dma_sel_VRAM_bank1=10.
- HDMA FF55=0x82 → status 0x02. Each mode 11→00 edge transfers one block; status reads 0x01, then 0x00, then 0xFF. No writes occur in modes 10/11/01, and only one block is written per H-blank.
- Cancel: HDMA with FF55=0x83, after one block write FF55=0x00 → status 0x82, IDLE, no further writes, dma_sel back to 00.
- Wrap: FF53=1F, FF54=F0, GDMA FF55=01 → first block 0x9FF0–0x9FFF, second block 0x8000–0x800F.
- Assert reset_n low mid-GDMA (byte 5) → all outputs 0 in the same cycle, status 0xFF, no writes after release.

Source files
------------

// File: rtl/vram_hdma_ctrl_if.sv
// ----------------------------------------------------------------------------
// vram_hdma_ctrl_if
// Bus bundle between the VRAM DMA controller and its neighbours.
//   CPU register port : reg_addr, reg_we, reg_wdata, hdma_status (FF55 readback)
//   Source read port  : src_addr, src_en, src_rdata (data valid one cycle after src_en)
//   VRAM write port   : address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr,
//                       wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr
// modport master : the DMA controller side
// modport slave  : the CPU / memory / PPU side
// ----------------------------------------------------------------------------
interface vram_hdma_ctrl_if;
    logic [15:0] reg_addr;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [7:0]  hdma_status;

    logic [15:0] src_addr;
    logic        src_en;
    logic [7:0]  src_rdata;

    logic [15:0] address_bus_dma_wr;
    logic        mem_enable_dma_wr;
    logic [7:0]  data_in_dma_wr;
    logic        wr_en_VRAM_bank0_dma_wr;
    logic        wr_en_VRAM_bank1_dma_wr;

    modport master (
        input  reg_addr, reg_we, reg_wdata, src_rdata,
        output hdma_status, src_addr, src_en,
        output address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr,
        output wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr
    );

    modport slave (
        output reg_addr, reg_we, reg_wdata, src_rdata,
        input  hdma_status, src_addr, src_en,
        input  address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr,
        input  wr_en_VRAM_bank0_dma_wr, wr_en_VRAM_bank1_dma_wr
    );
endinterface

// File: rtl/vram_hdma_ctrl.sv
// ----------------------------------------------------------------------------
// vram_hdma_ctrl
// CGB VRAM DMA controller (FF51-FF55). Copies 16-byte blocks from a source
// address into VRAM bank 0/1, either all blocks back-to-back (GDMA) or one
// block per H-blank entry (HDMA). Stalls the CPU while bytes are moving.
//
// Ports:
//   clk4_2, reset_n     clock, asynchronous active-low reset
//   bus (master)        CPU register port, source read port, VRAM write port
//   VBK                 VRAM bank select, captured on the FF55 start write
//   STAT_mode           PPU mode (00 H-blank, 01 V-blank, 10 OAM, 11 transfer)
//   LCD_on              LCDC[7]; when low, HDMA waits indefinitely
//   dma_sel_VRAM_bank*  2'b10 on the target bank while not idle
//   cpu_stall           high while reading/writing bytes
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transfer in progress
// RD      | source read cycle (src_en high)
// WR      | VRAM write cycle, then src/dst advance
// WAIT_HB | HDMA armed, waiting for a non-00 -> 00 STAT_mode edge
// HOLD    | HDMA block done, waiting for the H-blank to end
// ----------------------------------------------------------------------------
module vram_hdma_ctrl (
    input  logic                     clk4_2,
    input  logic                     reset_n,
    vram_hdma_ctrl_if.master         bus,
    input  logic                     VBK,
    input  logic [1:0]               STAT_mode,
    input  logic                     LCD_on,
    output logic [1:0]               dma_sel_VRAM_bank0,
    output logic [1:0]               dma_sel_VRAM_bank1,
    output logic                     cpu_stall
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_WR      = 3'd2,
        S_WAIT_HB = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t      state, state_n;
    logic [15:0] src;
    logic [12:0] dst;
    logic [3:0]  byte_cnt;
    logic [6:0]  len_m1;      // blocks_left - 1
    logic        is_hdma;
    logic        bank;
    logic [7:0]  status_q;
    logic [1:0]  prev_mode;

    logic wr_ff55, start_gdma, start_hdma, cancel, block_end, last_block, hb_edge;

    assign wr_ff55    = bus.reg_we && (bus.reg_addr == 16'hFF55);
    assign start_gdma = wr_ff55 && (state == S_IDLE) && !bus.reg_wdata[7];
    assign start_hdma = wr_ff55 && (state == S_IDLE) &&  bus.reg_wdata[7];
    assign cancel     = wr_ff55 && (state != S_IDLE) && is_hdma && !bus.reg_wdata[7];
    assign block_end  = (state == S_WR) && (byte_cnt == 4'hF);
    assign last_block = (len_m1 == 7'd0);
    // Edge, not level: a start issued inside an H-blank must wait for the next one.
    assign hb_edge    = (prev_mode != 2'b00) && (STAT_mode == 2'b00);

    assign bus.hdma_status = status_q;

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n                     = state;
        cpu_stall                   = 1'b0;
        bus.src_en                  = 1'b0;
        bus.src_addr                = 16'h0000;
        bus.mem_enable_dma_wr       = 1'b0;
        bus.address_bus_dma_wr      = 16'h0000;
        bus.data_in_dma_wr          = 8'h00;
        bus.wr_en_VRAM_bank0_dma_wr = 1'b0;
        bus.wr_en_VRAM_bank1_dma_wr = 1'b0;
        dma_sel_VRAM_bank0          = 2'b00;
        dma_sel_VRAM_bank1          = 2'b00;

        case (state)
            S_IDLE: begin
                if (start_gdma)      state_n = S_RD;
                else if (start_hdma) state_n = S_WAIT_HB;
            end
            S_RD: begin
                state_n      = S_WR;
                cpu_stall    = 1'b1;
                bus.src_en   = 1'b1;
                bus.src_addr = src;
            end
            S_WR: begin
                cpu_stall                   = 1'b1;
                bus.mem_enable_dma_wr       = 1'b1;
                bus.address_bus_dma_wr      = {3'b100, dst};
                bus.data_in_dma_wr          = bus.src_rdata;
                bus.wr_en_VRAM_bank0_dma_wr = !bank;
                bus.wr_en_VRAM_bank1_dma_wr = bank;
                if (byte_cnt != 4'hF)  state_n = S_RD;
                else if (last_block)   state_n = S_IDLE;
                else if (is_hdma)      state_n = S_HOLD;
                else                   state_n = S_RD;
            end
            S_WAIT_HB: begin
                if (hb_edge && LCD_on) state_n = S_RD;
            end
            S_HOLD: begin
                if (STAT_mode != 2'b00) state_n = S_WAIT_HB;
            end
            default: state_n = S_IDLE;
        endcase

        if (cancel) state_n = S_IDLE;

        if (state != S_IDLE) begin
            dma_sel_VRAM_bank0 = bank ? 2'b00 : 2'b10;
            dma_sel_VRAM_bank1 = bank ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            src       <= 16'h0000;
            dst       <= 13'h0000;
            byte_cnt  <= 4'h0;
            len_m1    <= 7'h00;
            is_hdma   <= 1'b0;
            bank      <= 1'b0;
            status_q  <= 8'hFF;
            prev_mode <= 2'b00;
        end else begin
            prev_mode <= STAT_mode;

            if (bus.reg_we && (state == S_IDLE)) begin
                case (bus.reg_addr)
                    16'hFF51: src <= {bus.reg_wdata, src[7:4], 4'h0};
                    16'hFF52: src <= {src[15:8], bus.reg_wdata[7:4], 4'h0};
                    16'hFF53: dst <= {bus.reg_wdata[4:0], dst[7:4], 4'h0};
                    16'hFF54: dst <= {dst[12:8], bus.reg_wdata[7:4], 4'h0};
                    default: ;
                endcase
            end

            if (start_gdma || start_hdma) begin
                len_m1   <= bus.reg_wdata[6:0];
                is_hdma  <= bus.reg_wdata[7];
                bank     <= VBK;
                byte_cnt <= 4'h0;
                status_q <= {1'b0, bus.reg_wdata[6:0]};
            end

            if (state == S_WR) begin
                src      <= src + 16'd1;
                dst      <= dst + 13'd1;
                byte_cnt <= byte_cnt + 4'd1;
                if (block_end) begin
                    if (last_block) begin
                        status_q <= 8'hFF;
                    end else begin
                        len_m1   <= len_m1 - 7'd1;
                        status_q <= {1'b0, len_m1 - 7'd1};
                    end
                end
            end

            // Cancel reports the blocks still outstanding with bit 7 set.
            if (cancel) status_q <= {1'b1, len_m1};
        end
    end

endmodule

// File: tb/tb_vram_hdma_ctrl.sv
module tb_vram_hdma_ctrl;

    logic       clk4_2;
    logic       reset_n;
    logic       VBK;
    logic [1:0] STAT_mode;
    logic       LCD_on;
    logic [1:0] sel0, sel1;
    logic       cpu_stall;

    vram_hdma_ctrl_if bus();

    vram_hdma_ctrl dut (
        .clk4_2             (clk4_2),
        .reset_n            (reset_n),
        .bus                (bus),
        .VBK                (VBK),
        .STAT_mode          (STAT_mode),
        .LCD_on             (LCD_on),
        .dma_sel_VRAM_bank0 (sel0),
        .dma_sel_VRAM_bank1 (sel1),
        .cpu_stall          (cpu_stall)
    );

    initial clk4_2 = 1'b0;
    always #5 clk4_2 = ~clk4_2;

    // Source memory: registered read, data valid the cycle after src_en.
    logic [7:0] smem [0:65535];
    always @(posedge clk4_2) begin
        if (bus.src_en) bus.src_rdata <= smem[bus.src_addr];
    end

    // Write/stall monitor. Each write is {wr_en1, wr_en0, addr, data}.
    logic [25:0] wq[$];
    int stall_cnt = 0;
    int nonhb_wr  = 0;
    always @(negedge clk4_2) begin
        if (reset_n) begin
            if (bus.mem_enable_dma_wr) begin
                wq.push_back({bus.wr_en_VRAM_bank1_dma_wr, bus.wr_en_VRAM_bank0_dma_wr,
                              bus.address_bus_dma_wr, bus.data_in_dma_wr});
                if (STAT_mode != 2'b00) nonhb_wr <= nonhb_wr + 1;
            end
            if (cpu_stall) stall_cnt <= stall_cnt + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns on a negedge.
    task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        bus.reg_we    = 1'b1;
        @(negedge clk4_2);
        bus.reg_we    = 1'b0;
    endtask

    task automatic set_ptrs(input logic [7:0] r51, input logic [7:0] r52,
                            input logic [7:0] r53, input logic [7:0] r54);
        reg_wr(16'hFF51, r51);
        reg_wr(16'hFF52, r52);
        reg_wr(16'hFF53, r53);
        reg_wr(16'hFF54, r54);
    endtask

    // Reference: n bytes copied linearly; src wraps at 16 bits, dst at 13 bits.
    task automatic check_writes(input int base, input int n, input logic [15:0] s0,
                                input logic [12:0] d0, input logic vbk, input string tag);
        logic [15:0] sa;
        logic [12:0] da;
        logic [25:0] exp;
        chk({tag, "_cnt"}, wq.size() - base, n);
        for (int i = 0; i < n; i++) begin
            sa  = s0 + 16'(i);
            da  = d0 + 13'(i);
            exp = {vbk, ~vbk, 3'b100, da, smem[sa]};
            if (base + i < wq.size()) chk({tag, "_wr"}, 32'(wq[base + i]), 32'(exp));
        end
    endtask

    task automatic run_gdma(input logic [7:0] r51, input logic [7:0] r52,
                            input logic [7:0] r53, input logic [7:0] r54,
                            input logic vbk, input logic [6:0] len, input string tag);
        logic [15:0] s0;
        logic [12:0] d0;
        int base, st0, cyc, budget;
        s0     = {r51, r52[7:4], 4'h0};
        d0     = {r53[4:0], r54[7:4], 4'h0};
        budget = 32 * (int'(len) + 1) + 40;
        set_ptrs(r51, r52, r53, r54);
        VBK  = vbk;
        base = wq.size();
        st0  = stall_cnt;
        reg_wr(16'hFF55, {1'b0, len});
        chk({tag, "_sel"}, {sel0, sel1}, vbk ? 4'b0010 : 4'b1000);
        chk({tag, "_stat_act"}, bus.hdma_status, {1'b0, len});
        cyc = 0;
        while (cpu_stall && cyc < budget) begin
            @(negedge clk4_2);
            cyc++;
        end
        repeat (5) @(negedge clk4_2);
        chk({tag, "_stall"}, stall_cnt - st0, 32 * (int'(len) + 1));
        chk({tag, "_stat_end"}, bus.hdma_status, 8'hFF);
        chk({tag, "_sel_end"}, {sel0, sel1}, 4'b0000);
        check_writes(base, 16 * (int'(len) + 1), s0, d0, vbk, tag);
    endtask

    // One PPU line: OAM, transfer, then H-blank; checks the first read one cycle after the edge.
    task automatic hblank(input logic expect_rd);
        STAT_mode = 2'b10;
        repeat (10) @(negedge clk4_2);
        STAT_mode = 2'b11;
        repeat (20) @(negedge clk4_2);
        STAT_mode = 2'b00;
        @(negedge clk4_2);
        chk("hb_rd_start", bus.src_en, expect_rd);
        repeat (50) @(negedge clk4_2);
    endtask

    initial begin
        logic       vbk_h;
        logic [6:0] len_r;
        int base, st0, nh0, remaining, cyc;

        reset_n       = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = 16'h0000;
        bus.reg_wdata = 8'h00;
        VBK           = 1'b0;
        STAT_mode     = 2'b01;
        LCD_on        = 1'b1;
        for (int i = 0; i < 65536; i++) smem[i] = 8'($urandom);

        repeat (3) @(negedge clk4_2);
        chk("rst_status", bus.hdma_status, 8'hFF);
        chk("rst_ctl", {cpu_stall, bus.src_en, bus.mem_enable_dma_wr,
                        bus.wr_en_VRAM_bank0_dma_wr, bus.wr_en_VRAM_bank1_dma_wr, sel0, sel1}, 0);
        chk("rst_addr", {bus.src_addr, bus.address_bus_dma_wr}, 0);
        reset_n = 1'b1;
        @(negedge clk4_2);

        // Directed GDMA cases.
        run_gdma(8'hC0, 8'h00, 8'h00, 8'h00, 1'b0, 7'd0, "gdma_basic");
        run_gdma(8'hC0, 8'h0F, 8'h00, 8'h1F, 1'b1, 7'd0, "gdma_mask");
        run_gdma(8'hC0, 8'h00, 8'h1F, 8'hF0, 1'b0, 7'd1, "gdma_dwrap");
        run_gdma(8'hFF, 8'hF0, 8'h05, 8'h30, 1'b1, 7'd1, "gdma_swrap");

        // Randomized GDMA.
        for (int k = 0; k < 4; k++) begin
            len_r = 7'($urandom_range(0, 3));
            run_gdma(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom), len_r, "gdma_rand");
        end

        // HDMA, three blocks.
        vbk_h = 1'($urandom);
        set_ptrs(8'hC1, 8'h30, 8'h0A, 8'h50);
        VBK       = vbk_h;
        STAT_mode = 2'b11;
        base      = wq.size();
        st0       = stall_cnt;
        nh0       = nonhb_wr;
        reg_wr(16'hFF55, 8'h82);
        chk("hdma_stat0", bus.hdma_status, 8'h02);
        repeat (10) @(negedge clk4_2);
        chk("hdma_idle_stall", cpu_stall, 1'b0);
        chk("hdma_nowr0", wq.size() - base, 0);
        chk("hdma_sel", {sel0, sel1}, vbk_h ? 4'b0010 : 4'b1000);
        for (int b = 0; b < 3; b++) begin
            hblank(1'b1);
            remaining = 2 - b;
            chk("hdma_blk_wr", wq.size() - base, 16 * (b + 1));
            chk("hdma_blk_stall", stall_cnt - st0, 32 * (b + 1));
            chk("hdma_blk_stat", bus.hdma_status, (remaining > 0) ? 8'(remaining - 1) : 8'hFF);
        end
        hblank(1'b0);
        chk("hdma_nowr_after", wq.size() - base, 48);
        chk("hdma_nonhb", nonhb_wr - nh0, 0);
        check_writes(base, 48, 16'hC130, 13'h0A50, vbk_h, "hdma");

        // Cancel: start inside H-blank, LCD off, one block, cancel.
        set_ptrs(8'hC3, 8'h80, 8'h13, 8'hC0);
        VBK  = 1'b0;
        base = wq.size();
        reg_wr(16'hFF55, 8'h83);
        repeat (40) @(negedge clk4_2);
        chk("cxl_start_in_hb", wq.size() - base, 0);
        chk("cxl_stat0", bus.hdma_status, 8'h03);
        LCD_on = 1'b0;
        hblank(1'b0);
        chk("cxl_lcd_off", wq.size() - base, 0);
        LCD_on = 1'b1;
        hblank(1'b1);
        chk("cxl_stat1", bus.hdma_status, 8'h02);
        reg_wr(16'hFF55, 8'h00);
        repeat (2) @(negedge clk4_2);
        chk("cxl_stat", bus.hdma_status, 8'h82);
        chk("cxl_sel", {sel0, sel1, 2'b00, 3'b000, cpu_stall}, 0);
        hblank(1'b0);
        check_writes(base, 16, 16'hC380, 13'h13C0, 1'b0, "cxl");

        // Reset during GDMA byte 5.
        STAT_mode = 2'b01;
        set_ptrs(8'hC2, 8'h00, 8'h02, 8'h00);
        VBK  = 1'b0;
        base = wq.size();
        reg_wr(16'hFF55, 8'h00);
        cyc = 0;
        while (wq.size() - base < 5 && cyc < 40) begin
            @(negedge clk4_2);
            cyc++;
        end
        chk("rst_wait", cyc < 40, 1'b1);
        @(posedge clk4_2);
        #2 reset_n = 1'b0;
        #1;
        chk("rstm_ctl", {cpu_stall, bus.src_en, bus.mem_enable_dma_wr,
                         bus.wr_en_VRAM_bank0_dma_wr, bus.wr_en_VRAM_bank1_dma_wr, sel0, sel1}, 0);
        chk("rstm_addr", {bus.src_addr, bus.address_bus_dma_wr}, 0);
        chk("rstm_data", bus.data_in_dma_wr, 8'h00);
        chk("rstm_status", bus.hdma_status, 8'hFF);
        @(negedge clk4_2);
        reset_n = 1'b1;
        st0 = stall_cnt;
        repeat (40) @(negedge clk4_2);
        chk("rstm_partial", wq.size() - base, 5);
        chk("rstm_nostall", stall_cnt - st0, 0);
        check_writes(base, 5, 16'hC200, 13'h0200, 1'b0, "rstm");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
